// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/IO requesters, the RAM and the mem_arbiter.
// The arbiter uses the slave modport; requesters and RAM sit on the master side.
interface mem_arbiter_if #(
    parameter int unsigned word_width = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic                  cpu_lock;
    logic [word_width-1:0] cpu_addr;
    logic [word_width-1:0] cpu_wdata;

    logic                  io_req;
    logic                  io_we;
    logic [word_width-1:0] io_addr;
    logic [word_width-1:0] io_wdata;

    logic                  cpu_gnt;
    logic                  io_gnt;
    logic                  cpu_ack;
    logic                  io_ack;
    logic [word_width-1:0] rdata;

    logic [word_width-1:0] ram_addr;
    logic [word_width-1:0] ram_din;
    logic [word_width-1:0] ram_dout;
    logic                  ram_oe;
    logic                  ram_we;

    logic                  busy;
    logic                  owner;

    modport master (
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output ram_dout,
        input  cpu_gnt, io_gnt, cpu_ack, io_ack, rdata,
        input  ram_addr, ram_din, ram_oe, ram_we,
        input  busy, owner
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  ram_dout,
        output cpu_gnt, io_gnt, cpu_ack, io_ack, rdata,
        output ram_addr, ram_din, ram_oe, ram_we,
        output busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/IO) single-port RAM arbiter: round-robin on ties, bounded
// CPU bus locking, fixed IDLE->GRANT->ACCESS->ACK sequence, all outputs registered.
module mem_arbiter #(
    parameter int unsigned word_width = 16,
    parameter int unsigned max_lock   = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned cnt_w = (max_lock > 1) ? $clog2(max_lock + 1) : 1;

    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_grant  = 2'd1,
        st_access = 2'd2,
        st_ack    = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Registered output and datapath state (_q) with next values (_d).
    logic                  cpu_gnt_q, cpu_gnt_d;
    logic                  io_gnt_q, io_gnt_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  io_ack_q, io_ack_d;
    logic                  ram_oe_q, ram_oe_d;
    logic                  ram_we_q, ram_we_d;
    logic [word_width-1:0] ram_addr_q, ram_addr_d;
    logic [word_width-1:0] ram_din_q, ram_din_d;
    logic [word_width-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  owner_q, owner_d;
    logic [cnt_w-1:0]      lock_cnt_q, lock_cnt_d;

    logic                  win_io;
    logic                  lock_go;
    logic                  sel_we;
    logic [word_width-1:0] sel_addr;
    logic [word_width-1:0] sel_wdata;

    // The current owner's request fields, latched into the RAM-side registers in GRANT.
    assign sel_we    = owner_q ? bus.io_we    : bus.cpu_we;
    assign sel_addr  = owner_q ? bus.io_addr  : bus.cpu_addr;
    assign sel_wdata = owner_q ? bus.io_wdata : bus.cpu_wdata;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= st_idle;
            cpu_gnt_q  <= 1'b0;
            io_gnt_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            io_ack_q   <= 1'b0;
            ram_oe_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            owner_q    <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cpu_gnt_q  <= cpu_gnt_d;
            io_gnt_q   <= io_gnt_d;
            cpu_ack_q  <= cpu_ack_d;
            io_ack_q   <= io_ack_d;
            ram_oe_q   <= ram_oe_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state and arbitration; a tie goes to whoever is not the current owner.
    always_comb begin
        state_d = state_q;
        win_io  = owner_q;
        lock_go = 1'b0;
        case (state_q)
            st_idle: begin
                if (bus.cpu_req || bus.io_req) begin
                    state_d = st_grant;
                    win_io  = bus.io_req && (!bus.cpu_req || !owner_q);
                end
            end
            st_grant:  state_d = st_access;
            st_access: state_d = st_ack;
            st_ack: begin
                if (!owner_q && bus.cpu_lock && bus.cpu_req
                    && (lock_cnt_q < cnt_w'(max_lock - 1))) begin
                    state_d = st_grant;
                    win_io  = 1'b0;
                    lock_go = 1'b1;
                end else begin
                    state_d = st_idle;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Output/datapath next values, registered by the block above.
    always_comb begin
        cpu_gnt_d  = 1'b0;
        io_gnt_d   = 1'b0;
        cpu_ack_d  = 1'b0;
        io_ack_d   = 1'b0;
        ram_oe_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_din_d  = '0;
        ram_addr_d = ram_addr_q;
        rdata_d    = rdata_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        busy_d     = (state_d != st_idle);

        if (state_d == st_grant) begin
            owner_d   = win_io;
            cpu_gnt_d = !win_io;
            io_gnt_d  = win_io;
        end

        if (state_q == st_grant) begin
            ram_addr_d = sel_addr;
            ram_we_d   = sel_we;
            ram_oe_d   = !sel_we;
            ram_din_d  = sel_we ? sel_wdata : '0;
        end

        if (state_q == st_access) begin
            cpu_ack_d = !owner_q;
            io_ack_d  = owner_q;
            if (ram_oe_q) begin
                rdata_d = bus.ram_dout;
            end
        end

        if (state_q == st_ack) begin
            lock_cnt_d = lock_go ? (lock_cnt_q + cnt_w'(1)) : '0;
        end
    end

    assign bus.cpu_gnt  = cpu_gnt_q;
    assign bus.io_gnt   = io_gnt_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.io_ack   = io_ack_q;
    assign bus.ram_oe   = ram_oe_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small behavioural RAM and
// hand-computed expectations for each cycle of interest.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    logic [15:0] mem [256];

    mem_arbiter_if #(.word_width(16)) bus ();

    mem_arbiter #(.word_width(16), .max_lock(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the strobe.
    always_comb bus.ram_dout = mem[bus.ram_addr[7:0]];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_din;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge; strobes must stay exclusive.
    task automatic tick();
        @(posedge clk);
        #1;
        check("oe_we_excl", 32'(bus.ram_oe & bus.ram_we), 32'd0);
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_lock = 1'b0;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.io_req = 1'b0;  bus.io_we = 1'b0;
        bus.io_addr = '0;   bus.io_wdata = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mem[8'h10] = 16'hBEEF;
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_owner", 32'(bus.owner),    32'd1);
        check("rst_gnt",   32'({bus.cpu_gnt, bus.io_gnt, bus.cpu_ack, bus.io_ack}), 32'd0);
        check("rst_strb",  32'({bus.ram_oe, bus.ram_we}), 32'd0);
        check("rst_rdata", 32'(bus.rdata),    32'd0);
        check("rst_addr",  32'(bus.ram_addr), 32'd0);
        check("rst_din",   32'(bus.ram_din),  32'd0);
        rst = 1'b1;

        // CPU read of 0x0010.
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
        tick();
        check("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        check("rd_io_gnt",  32'(bus.io_gnt),  32'd0);
        check("rd_busy",    32'(bus.busy),    32'd1);
        check("rd_owner",   32'(bus.owner),   32'd0);
        bus.cpu_req = 1'b0;
        tick();
        check("rd_gnt_pulse", 32'(bus.cpu_gnt),  32'd0);
        check("rd_oe",        32'(bus.ram_oe),   32'd1);
        check("rd_addr",      32'(bus.ram_addr), 32'h0010);
        check("rd_din0",      32'(bus.ram_din),  32'd0);
        tick();
        check("rd_ack",   32'(bus.cpu_ack), 32'd1);
        check("rd_rdata", 32'(bus.rdata),   32'hBEEF);
        check("rd_oe_off", 32'(bus.ram_oe), 32'd0);
        tick();
        check("rd_idle", 32'(bus.busy),    32'd0);
        check("rd_ack1", 32'(bus.cpu_ack), 32'd0);

        // IO write of 0x1234 to 0x0020.
        bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 16'h0020; bus.io_wdata = 16'h1234;
        tick();
        check("wr_io_gnt", 32'(bus.io_gnt), 32'd1);
        check("wr_owner",  32'(bus.owner),  32'd1);
        bus.io_req = 1'b0;
        tick();
        check("wr_we",   32'(bus.ram_we),   32'd1);
        check("wr_din",  32'(bus.ram_din),  32'h1234);
        check("wr_addr", 32'(bus.ram_addr), 32'h0020);
        tick();
        check("wr_ack",      32'(bus.io_ack),  32'd1);
        check("wr_din_zero", 32'(bus.ram_din), 32'd0);
        check("wr_rdata_hold", 32'(bus.rdata), 32'hBEEF);
        check("wr_mem",      32'(mem[8'h20]),  32'h1234);
        tick();
        check("wr_idle", 32'(bus.busy), 32'd0);
        clear_inputs();

        // Round robin after a fresh reset, both requesting reads.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
        bus.io_req  = 1'b1; bus.io_addr  = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_cpu_gnt", 32'(bus.cpu_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_io_gnt",  32'(bus.io_gnt),  (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            tick();
            check("rr_ack", 32'({bus.cpu_ack, bus.io_ack}), (k % 2 == 0) ? 32'd2 : 32'd1);
            check("rr_rdata", 32'(bus.rdata), (k % 2 == 0) ? 32'hBEEF : 32'h1234);
            tick();
            check("rr_idle", 32'(bus.busy), 32'd0);
        end

        // Locked CPU burst: four back-to-back transactions, then IO.
        bus.cpu_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("lk_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
            check("lk_busy",    32'(bus.busy),    32'd1);
            tick();
            tick();
            check("lk_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        end
        tick();
        check("lk_yield_idle", 32'(bus.busy),    32'd0);
        check("lk_yield_gnt",  32'(bus.cpu_gnt), 32'd0);
        tick();
        check("lk_io_gnt", 32'(bus.io_gnt), 32'd1);
        tick();
        tick();
        check("lk_io_ack", 32'(bus.io_ack), 32'd1);
        tick();
        check("lk_io_no_lock", 32'(bus.busy), 32'd0);
        clear_inputs();
        tick();
        tick();
        tick();
        tick();
        check("lk_drained", 32'(bus.busy), 32'd0);

        // Reset asserted during a write ACCESS aborts it.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 16'h5555;
        tick();
        check("ab_gnt", 32'(bus.cpu_gnt), 32'd1);
        bus.cpu_req = 1'b0;
        tick();
        check("ab_we", 32'(bus.ram_we), 32'd1);
        rst = 1'b0;
        tick();
        check("ab_we_off", 32'(bus.ram_we),  32'd0);
        check("ab_busy",   32'(bus.busy),    32'd0);
        check("ab_owner",  32'(bus.owner),   32'd1);
        check("ab_no_ack", 32'(bus.cpu_ack), 32'd0);
        rst = 1'b1;
        tick();
        check("ab_no_ack2", 32'(bus.cpu_ack), 32'd0);
        check("ab_idle",    32'(bus.busy),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
